// File: rtl/bridge_pkg.sv
// Shared types, AHB encodings and the byte-strobe helper for the AHB-to-APB sequencer.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4,
        ERR1   = 3'd5,
        ERR2   = 3'd6
    } seq_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    function automatic logic [3:0] apb_strb(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        strb = '0;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
            HSIZE_WORD: strb = 4'hF;
            default:    strb = '0;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/bridge_apb_sequencer_if.sv
// AHB-Lite and APB bus bundles; the bridge is the AHB slave and the APB master.
interface ahb_lite_if #(parameter int WIDTH = 32);
    logic             HSEL;
    logic [1:0]       HTRANS;
    logic [WIDTH-1:0] HADDR;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [WIDTH-1:0] HWDATA;
    logic             HREADY;
    logic             HREADY_OUT;
    logic             HRESP;
    logic [WIDTH-1:0] HRDATA;

    modport master (output HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, HREADY,
                    input  HREADY_OUT, HRESP, HRDATA);
    modport slave  (input  HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, HREADY,
                    output HREADY_OUT, HRESP, HRDATA);
endinterface

interface apb_if #(parameter int WIDTH = 32, parameter int SLAVES = 4);
    logic [WIDTH-1:0]  PADDR;
    logic [WIDTH-1:0]  PWDATA;
    logic [3:0]        PSTRB;
    logic [SLAVES-1:0] PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [WIDTH-1:0]  PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (output PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/bridge_apb_decode.sv
// Combinational address/size decode: peripheral slot, one-hot select, byte strobe and fault flag.
module bridge_apb_decode
    import bridge_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               SLAVES = 4,
    parameter logic [WIDTH-1:0] BASE   = 32'h8000_0000
) (
    input  logic [WIDTH-1:0]  HADDR,
    input  logic [2:0]        HSIZE,
    output logic [3:0]        slot,
    output logic [SLAVES-1:0] sel,
    output logic [3:0]        strb,
    output logic              err
);

    logic unused_addr_bits;
    assign unused_addr_bits = ^HADDR[11:2];

    // Any region, slot range, size or alignment fault suppresses the select entirely.
    always_comb begin
        slot = HADDR[15:12];
        strb = apb_strb(HSIZE, HADDR[1:0]);
        err  = 1'b0;
        sel  = '0;
        if (HADDR[WIDTH-1:16] != BASE[WIDTH-1:16])          err = 1'b1;
        if ({28'd0, slot} >= SLAVES)                        err = 1'b1;
        if (HSIZE > HSIZE_WORD)                             err = 1'b1;
        if (HSIZE == HSIZE_HALF && HADDR[0])                err = 1'b1;
        if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)     err = 1'b1;
        for (int i = 0; i < SLAVES; i++) begin
            if (!err && slot == 4'(i)) sel[i] = 1'b1;
        end
    end

endmodule

// File: rtl/bridge_apb_sequencer.sv
// AHB-Lite slave that runs one APB SETUP/ACCESS transfer per accepted AHB transfer,
// with wait-state timeout and two-cycle ERROR responses.
module bridge_apb_sequencer
    import bridge_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               SLAVES  = 4,
    parameter logic [WIDTH-1:0] BASE    = 32'h8000_0000,
    parameter int               TIMEOUT = 15
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    ahb_lite_if.slave   ahb,
    apb_if.master       apb,
    output logic        apb_timeout
);

    localparam logic [7:0] TIMER_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    seq_state_t        state, state_next;
    logic [3:0]        dec_slot;
    logic [SLAVES-1:0] dec_sel;
    logic [3:0]        dec_strb;
    logic              dec_err;
    logic [SLAVES-1:0] sel_q;
    logic [7:0]        timer;
    logic              can_accept;
    logic              accept;
    logic              timeout_hit;
    logic              unused_slot_bits;

    bridge_apb_decode #(
        .WIDTH  (WIDTH),
        .SLAVES (SLAVES),
        .BASE   (BASE)
    ) u_decode (
        .HADDR (ahb.HADDR),
        .HSIZE (ahb.HSIZE),
        .slot  (dec_slot),
        .sel   (dec_sel),
        .strb  (dec_strb),
        .err   (dec_err)
    );

    assign unused_slot_bits = ^{dec_slot, ahb.HTRANS[0]};

    assign can_accept  = (state == IDLE) || (state == DONE) || (state == ERR2);
    assign accept      = can_accept && ahb.HSEL && ahb.HTRANS[1] && ahb.HREADY;
    assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !apb.PREADY && (timer == TIMER_LAST);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_next;
    end

    // DONE and ERR2 are also address-phase cycles, so back-to-back transfers need no idle gap.
    always_comb begin
        state_next     = state;
        ahb.HREADY_OUT = 1'b0;
        ahb.HRESP      = 1'b0;
        apb.PSEL       = '0;
        apb.PENABLE    = 1'b0;
        case (state)
            IDLE, DONE, ERR2: begin
                ahb.HREADY_OUT = 1'b1;
                ahb.HRESP      = (state == ERR2);
                if (accept)        state_next = dec_err ? ERR1 : (ahb.HWRITE ? WDATA : SETUP);
                else               state_next = IDLE;
            end
            WDATA: state_next = SETUP;
            SETUP: begin
                apb.PSEL   = sel_q;
                state_next = ACCESS;
            end
            ACCESS: begin
                apb.PSEL    = sel_q;
                apb.PENABLE = 1'b1;
                if (apb.PREADY)    state_next = apb.PSLVERR ? ERR1 : DONE;
                else if (timeout_hit) state_next = ERR1;
            end
            ERR1: begin
                ahb.HRESP  = 1'b1;
                state_next = ERR2;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields only move on a clean accept, so faulted accepts leave the APB bus untouched.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            apb.PSTRB   <= '0;
            apb.PWRITE  <= 1'b0;
            sel_q       <= '0;
            timer       <= '0;
            ahb.HRDATA  <= '0;
            apb_timeout <= 1'b0;
        end else begin
            apb_timeout <= timeout_hit;
            if (accept && !dec_err) begin
                apb.PADDR  <= ahb.HADDR;
                apb.PWRITE <= ahb.HWRITE;
                apb.PSTRB  <= ahb.HWRITE ? dec_strb : 4'b0000;
                sel_q      <= dec_sel;
            end
            case (state)
                WDATA: apb.PWDATA <= ahb.HWDATA;
                SETUP: timer <= '0;
                ACCESS: begin
                    if (apb.PREADY && !apb.PSLVERR && !apb.PWRITE) ahb.HRDATA <= apb.PRDATA;
                    if (!apb.PREADY && !timeout_hit)              timer <= timer + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_apb_sequencer.sv
// Directed bench for the AHB-to-APB sequencer: reads, waited writes, faults, timeout, back-to-back, reset.
module tb_bridge_apb_sequencer;
    import bridge_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic apb_timeout;
    int   checks = 0;
    int   errors = 0;
    int   access_count;
    int   pulses;

    ahb_lite_if #(.WIDTH(32))             ahb ();
    apb_if      #(.WIDTH(32), .SLAVES(4)) apb ();

    bridge_apb_sequencer #(
        .WIDTH   (32),
        .SLAVES  (4),
        .BASE    (32'h8000_0000),
        .TIMEOUT (15)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .ahb         (ahb),
        .apb         (apb),
        .apb_timeout (apb_timeout)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic start(input logic [31:0] addr, input logic write, input logic [2:0] size);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = HTRANS_NONSEQ;
        ahb.HADDR  = addr;
        ahb.HWRITE = write;
        ahb.HSIZE  = size;
    endtask

    task automatic idle_bus();
        ahb.HTRANS = HTRANS_IDLE;
        ahb.HSEL   = 1'b0;
    endtask

    initial begin
        HRESETn     = 1'b0;
        ahb.HSEL    = 1'b0;
        ahb.HTRANS  = HTRANS_IDLE;
        ahb.HADDR   = '0;
        ahb.HWRITE  = 1'b0;
        ahb.HSIZE   = HSIZE_WORD;
        ahb.HWDATA  = '0;
        ahb.HREADY  = 1'b1;
        apb.PRDATA  = '0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        #1;
        check("rst_hready_out", 32'(ahb.HREADY_OUT), 32'd1);
        check("rst_hresp", 32'(ahb.HRESP), 32'd0);
        check("rst_psel", 32'(apb.PSEL), 32'd0);
        check("rst_paddr", apb.PADDR, 32'd0);
        check("rst_hrdata", ahb.HRDATA, 32'd0);
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        tick();

        $display("[TB] read at BASE|0x1004");
        start(32'h8000_1004, 1'b0, HSIZE_WORD);
        apb.PREADY = 1'b1;
        apb.PRDATA = 32'hDEAD_BEEF;
        check("rd_t0_hready", 32'(ahb.HREADY_OUT), 32'd1);
        tick(); idle_bus();
        check("rd_t1_psel", 32'(apb.PSEL), 32'h2);
        check("rd_t1_penable", 32'(apb.PENABLE), 32'd0);
        check("rd_t1_hready", 32'(ahb.HREADY_OUT), 32'd0);
        check("rd_t1_paddr", apb.PADDR, 32'h8000_1004);
        check("rd_t1_pstrb", 32'(apb.PSTRB), 32'd0);
        tick();
        check("rd_t2_psel", 32'(apb.PSEL), 32'h2);
        check("rd_t2_penable", 32'(apb.PENABLE), 32'd1);
        check("rd_t2_hready", 32'(ahb.HREADY_OUT), 32'd0);
        tick();
        check("rd_t3_hready", 32'(ahb.HREADY_OUT), 32'd1);
        check("rd_t3_hrdata", ahb.HRDATA, 32'hDEAD_BEEF);
        check("rd_t3_hresp", 32'(ahb.HRESP), 32'd0);
        check("rd_t3_psel", 32'(apb.PSEL), 32'd0);
        apb.PREADY = 1'b0;
        tick();

        $display("[TB] halfword write with three wait states");
        start(32'h8000_2002, 1'b1, HSIZE_HALF);
        tick(); idle_bus();
        ahb.HWDATA = 32'hBEEF_0000;
        check("hw_t1_hready", 32'(ahb.HREADY_OUT), 32'd0);
        check("hw_t1_psel", 32'(apb.PSEL), 32'd0);
        tick();
        ahb.HWDATA = 32'h1111_2222;
        check("hw_setup_psel", 32'(apb.PSEL), 32'h4);
        check("hw_setup_pstrb", 32'(apb.PSTRB), 32'hC);
        check("hw_setup_pwdata", apb.PWDATA, 32'hBEEF_0000);
        check("hw_setup_pwrite", 32'(apb.PWRITE), 32'd1);
        check("hw_setup_penable", 32'(apb.PENABLE), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("hw_access_penable", 32'(apb.PENABLE), 32'd1);
            check("hw_access_pwdata", apb.PWDATA, 32'hBEEF_0000);
            check("hw_access_hready", 32'(ahb.HREADY_OUT), 32'd0);
            if (i == 3) apb.PREADY = 1'b1;
            tick();
        end
        apb.PREADY = 1'b0;
        check("hw_t7_hready", 32'(ahb.HREADY_OUT), 32'd1);
        check("hw_t7_psel", 32'(apb.PSEL), 32'd0);
        check("hw_t7_hresp", 32'(ahb.HRESP), 32'd0);
        tick();

        $display("[TB] word write answered with PSLVERR");
        start(32'h8000_3000, 1'b1, HSIZE_WORD);
        tick(); idle_bus();
        ahb.HWDATA = 32'h1234_5678;
        tick();
        check("se_setup_psel", 32'(apb.PSEL), 32'h8);
        check("se_setup_pstrb", 32'(apb.PSTRB), 32'hF);
        tick();
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b1;
        check("se_access_pwdata", apb.PWDATA, 32'h1234_5678);
        tick();
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        check("se_err1_hresp", 32'(ahb.HRESP), 32'd1);
        check("se_err1_hready", 32'(ahb.HREADY_OUT), 32'd0);
        check("se_err1_psel", 32'(apb.PSEL), 32'd0);
        tick();
        check("se_err2_hresp", 32'(ahb.HRESP), 32'd1);
        check("se_err2_hready", 32'(ahb.HREADY_OUT), 32'd1);
        tick();
        check("se_idle_hresp", 32'(ahb.HRESP), 32'd0);
        check("se_idle_hready", 32'(ahb.HREADY_OUT), 32'd1);

        $display("[TB] BUSY transfer is ignored");
        start(32'h8000_1000, 1'b0, HSIZE_WORD);
        ahb.HTRANS = HTRANS_BUSY;
        tick(); idle_bus();
        check("busy_hready", 32'(ahb.HREADY_OUT), 32'd1);
        check("busy_psel", 32'(apb.PSEL), 32'd0);

        $display("[TB] decode and alignment faults");
        start(32'h8000_5000, 1'b0, HSIZE_WORD);
        tick(); idle_bus();
        check("dec_err1_hresp", 32'(ahb.HRESP), 32'd1);
        check("dec_err1_hready", 32'(ahb.HREADY_OUT), 32'd0);
        check("dec_err1_psel", 32'(apb.PSEL), 32'd0);
        tick();
        check("dec_err2_hresp", 32'(ahb.HRESP), 32'd1);
        check("dec_err2_hready", 32'(ahb.HREADY_OUT), 32'd1);
        start(32'h8000_1002, 1'b0, HSIZE_WORD);
        tick(); idle_bus();
        check("aln_err1_hresp", 32'(ahb.HRESP), 32'd1);
        check("aln_err1_hready", 32'(ahb.HREADY_OUT), 32'd0);
        check("aln_err1_psel", 32'(apb.PSEL), 32'd0);
        tick();
        check("aln_err2_hresp", 32'(ahb.HRESP), 32'd1);
        check("aln_err2_psel", 32'(apb.PSEL), 32'd0);
        check("aln_paddr_held", apb.PADDR, 32'h8000_3000);
        tick();

        $display("[TB] stalled peripheral timeout");
        start(32'h8000_0000, 1'b0, HSIZE_WORD);
        tick(); idle_bus();
        tick();
        access_count = 0;
        pulses       = 0;
        for (int i = 0; i < 40; i++) begin
            if (apb_timeout === 1'b1) pulses++;
            if (apb.PENABLE !== 1'b1) break;
            access_count++;
            tick();
        end
        check("to_access_cycles", 32'(access_count), 32'd15);
        check("to_err1_psel", 32'(apb.PSEL), 32'd0);
        check("to_err1_hresp", 32'(ahb.HRESP), 32'd1);
        check("to_err1_hready", 32'(ahb.HREADY_OUT), 32'd0);
        tick();
        if (apb_timeout === 1'b1) pulses++;
        check("to_err2_hresp", 32'(ahb.HRESP), 32'd1);
        check("to_err2_hready", 32'(ahb.HREADY_OUT), 32'd1);
        tick();
        if (apb_timeout === 1'b1) pulses++;
        check("to_pulse_count", 32'(pulses), 32'd1);
        check("to_idle_hresp", 32'(ahb.HRESP), 32'd0);

        $display("[TB] read accepted in the DONE cycle");
        start(32'h8000_1008, 1'b0, HSIZE_WORD);
        apb.PREADY = 1'b1;
        apb.PRDATA = 32'hCAFE_F00D;
        tick(); idle_bus();
        tick();
        tick();
        check("b2b_done_hrdata", ahb.HRDATA, 32'hCAFE_F00D);
        check("b2b_done_hready", 32'(ahb.HREADY_OUT), 32'd1);
        start(32'h8000_2000, 1'b0, HSIZE_WORD);
        apb.PRDATA = 32'h0BAD_C0DE;
        tick(); idle_bus();
        check("b2b_setup_psel", 32'(apb.PSEL), 32'h4);
        check("b2b_setup_penable", 32'(apb.PENABLE), 32'd0);
        check("b2b_setup_paddr", apb.PADDR, 32'h8000_2000);
        tick();
        tick();
        check("b2b_done2_hrdata", ahb.HRDATA, 32'h0BAD_C0DE);
        apb.PREADY = 1'b0;
        tick();

        $display("[TB] reset asserted during ACCESS");
        start(32'h8000_1000, 1'b1, HSIZE_BYTE);
        tick(); idle_bus();
        ahb.HWDATA = 32'h0000_00A5;
        tick();
        tick();
        check("rsta_penable", 32'(apb.PENABLE), 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        check("rsta_hready", 32'(ahb.HREADY_OUT), 32'd1);
        check("rsta_hresp", 32'(ahb.HRESP), 32'd0);
        check("rsta_psel", 32'(apb.PSEL), 32'd0);
        check("rsta_penable0", 32'(apb.PENABLE), 32'd0);
        check("rsta_paddr", apb.PADDR, 32'd0);
        check("rsta_pwdata", apb.PWDATA, 32'd0);
        check("rsta_pstrb", 32'(apb.PSTRB), 32'd0);
        check("rsta_pwrite", 32'(apb.PWRITE), 32'd0);
        check("rsta_hrdata", ahb.HRDATA, 32'd0);
        check("rsta_timeout", 32'(apb_timeout), 32'd0);
        #1 HRESETn = 1'b1;
        tick();
        check("rsta_idle_hready", 32'(ahb.HREADY_OUT), 32'd1);
        start(32'h8000_3000, 1'b0, HSIZE_WORD);
        tick(); idle_bus();
        check("rsta_next_psel", 32'(apb.PSEL), 32'h8);
        check("rsta_next_penable", 32'(apb.PENABLE), 32'd0);
        apb.PREADY = 1'b1;
        tick();
        tick();
        apb.PREADY = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
